rx_link_ctrl: RTL

- Link-bring-up controller for the PHY receive path, running in the clk_4f domain downstream of serial_paralelo_rx.
- Sequences the receiver:
  - pulses its reset;
  - waits for comma alignment (active);
  - counts training COM symbols;
  - once the link is up, forwards payload bytes while stripping COM/IDL.
- Detects loss of alignment or valid gaps and re-runs bring-up automatically.

---
 rtl/rx_link_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rx_link_ctrl.sv
// Link bring-up controller for the PHY receive path (clk_4f domain).
// Define RX_LINK_CTRL_STATS_EN to add the byte_cnt/drop_cnt statistics ports.
module rx_link_ctrl #(
  parameter logic [7:0] COM_SYM   = 8'hBC,
  parameter logic [7:0] IDL_SYM   = 8'h7C,
  parameter int         RST_HOLD  = 4,
  parameter int         TRAIN_CNT = 4,
  parameter int         TIMEOUT   = 64,
  parameter int         GAP_LIMIT = 3
) (
  input  logic       clk_4f,
  input  logic       rst_L,
  input  logic [7:0] sp_out,
  input  logic       valid_out_sp,
  input  logic       active,
  output logic       sp_rst_L,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       link_up,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_out
`ifdef RX_LINK_CTRL_STATS_EN
  ,
  output logic [15:0] byte_cnt,
  output logic [7:0]  drop_cnt
`endif
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_ACTIVE = 3'd1,
    TRAIN       = 3'd2,
    LINK_UP     = 3'd3,
    RETRAIN     = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [7:0]      to_cnt, to_nxt;
  logic [3:0]      com_cnt, com_nxt;
  logic [2:0]      gap_cnt, gap_nxt;
  logic [7:0]      data_nxt;
  logic            vld_nxt;
  logic            retry_inc;
  logic            drop_inc;
  logic [3:0]      retry_nxt;

  always_comb begin
    state_nxt = state;
    hold_nxt  = '0;
    to_nxt    = '0;
    com_nxt   = '0;
    gap_nxt   = '0;
    data_nxt  = data_out;
    vld_nxt   = 1'b0;
    retry_inc = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (hold_cnt == HW'(RST_HOLD - 1)) state_nxt = WAIT_ACTIVE;
        else                                hold_nxt  = hold_cnt + 1'b1;
      end
      WAIT_ACTIVE: begin
        to_nxt = to_cnt + 8'd1;
        if (active) state_nxt = TRAIN;
        else if (to_cnt == 8'(TIMEOUT - 1)) begin
          state_nxt = IDLE;
          retry_inc = 1'b1;
        end
      end
      TRAIN: begin
        to_nxt  = to_cnt + 8'd1;
        com_nxt = com_cnt;
        if (valid_out_sp) com_nxt = (sp_out == COM_SYM) ? com_cnt + 4'd1 : 4'd0;
        // Losing alignment beats a completed COM count on the same edge.
        if (!active) begin
          state_nxt = IDLE;
          retry_inc = 1'b1;
        end else if (com_nxt == 4'(TRAIN_CNT)) begin
          state_nxt = LINK_UP;
        end else if (to_cnt == 8'(TIMEOUT - 1)) begin
          state_nxt = IDLE;
          retry_inc = 1'b1;
        end
      end
      LINK_UP: begin
        gap_nxt = valid_out_sp ? 3'd0 : gap_cnt + 3'd1;
        if (!active || gap_nxt == 3'(GAP_LIMIT)) begin
          state_nxt = RETRAIN;
        end else if (valid_out_sp) begin
          if (sp_out == COM_SYM || sp_out == IDL_SYM) begin
            drop_inc = 1'b1;
          end else begin
            data_nxt = sp_out;
            vld_nxt  = 1'b1;
          end
        end
      end
      RETRAIN: begin
        state_nxt = IDLE;
        retry_inc = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign retry_nxt = (retry_inc && retry_cnt != 4'hF) ? retry_cnt + 4'd1 : retry_cnt;

  always_ff @(posedge clk_4f) begin
    if (!rst_L) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      to_cnt    <= '0;
      com_cnt   <= '0;
      gap_cnt   <= '0;
      sp_rst_L  <= 1'b0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      link_up   <= 1'b0;
      retry_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      to_cnt    <= to_nxt;
      com_cnt   <= com_nxt;
      gap_cnt   <= gap_nxt;
      // Receiver stays in reset for every cycle spent in IDLE.
      sp_rst_L  <= (state_nxt != IDLE);
      data_out  <= data_nxt;
      valid_out <= vld_nxt;
      link_up   <= (state_nxt == LINK_UP);
      retry_cnt <= retry_nxt;
    end
  end

  assign state_out = state;

`ifdef RX_LINK_CTRL_STATS_EN
  always_ff @(posedge clk_4f) begin
    if (!rst_L) begin
      byte_cnt <= 16'h0000;
      drop_cnt <= 8'h00;
    end else begin
      if (vld_nxt) byte_cnt <= byte_cnt + 16'd1;
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule
